// File: rtl/gerador_nota_if.sv
// Note-command link between the song sequencer (master) and the tone generator (slave).
interface gerador_nota_if #(
    parameter int unsigned WIDTH = 28
);
    logic             ena;
    logic             load;
    logic [WIDTH-1:0] freq_in;
    logic [WIDTH-1:0] dur_in;
    logic             tone_out;
    logic             duracao;
    logic             note_done;

    modport master (
        output ena, load, freq_in, dur_in,
        input  tone_out, duracao, note_done
    );

    modport slave (
        input  ena, load, freq_in, dur_in,
        output tone_out, duracao, note_done
    );
endinterface

// File: rtl/gerador_nota.sv
// Square-wave tone and note-duration generator fed by the song sequencer.
// Optional NOTE_GAP_EN macro adds a silent articulation tail of GAP_CYCLES to long notes.
module gerador_nota #(
    parameter int unsigned WIDTH = 28
`ifdef NOTE_GAP_EN
    ,
    parameter int unsigned GAP_CYCLES = 1_250_000
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    gerador_nota_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StPlay
`ifdef NOTE_GAP_EN
        ,
        StGap
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] freq_q, freq_d;
    logic [WIDTH-1:0] dur_cnt_q, dur_cnt_d;
    logic [WIDTH-1:0] tone_cnt_q, tone_cnt_d;
    logic             tone_q, tone_d;
    logic             done_q, done_d;
`ifdef NOTE_GAP_EN
    logic             gap_en_q, gap_en_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            freq_q     <= '0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef NOTE_GAP_EN
            gap_en_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
`ifdef NOTE_GAP_EN
            gap_en_q   <= gap_en_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        done_d     = 1'b0;
`ifdef NOTE_GAP_EN
        gap_en_d   = gap_en_q;
`endif

        unique case (state_q)
            StIdle: begin
                tone_d     = 1'b0;
                tone_cnt_d = '0;
            end
            StPlay: begin
                if (bus.ena) begin
                    if (dur_cnt_q == '0) begin
                        state_d = StIdle;
                        tone_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        dur_cnt_d = dur_cnt_q - WIDTH'(1);
                        if (freq_q == '0) begin
                            tone_d     = 1'b0;
                            tone_cnt_d = '0;
                        end else if (tone_cnt_q == freq_q - WIDTH'(1)) begin
                            tone_cnt_d = '0;
                            tone_d     = ~tone_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + WIDTH'(1);
                        end
`ifdef NOTE_GAP_EN
                        // dur_cnt counts remaining cycles, so this leaves exactly GAP_CYCLES silent
                        if (gap_en_q && dur_cnt_q == WIDTH'(GAP_CYCLES)) begin
                            state_d    = StGap;
                            tone_d     = 1'b0;
                            tone_cnt_d = tone_cnt_q;
                        end
`endif
                    end
                end
            end
`ifdef NOTE_GAP_EN
            StGap: begin
                tone_d = 1'b0;
                if (bus.ena) begin
                    if (dur_cnt_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        dur_cnt_d = dur_cnt_q - WIDTH'(1);
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // A load overrides everything above but keeps the done pulse of a note expiring now
        if (bus.load) begin
            freq_d     = bus.freq_in;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
            if (bus.dur_in == '0) begin
                dur_cnt_d = '0;
                state_d   = StIdle;
                done_d    = 1'b1;
            end else begin
                dur_cnt_d = bus.dur_in - WIDTH'(1);
                state_d   = StPlay;
            end
`ifdef NOTE_GAP_EN
            gap_en_d = {1'b0, bus.dur_in} > (WIDTH + 1)'(2 * GAP_CYCLES);
`endif
        end
    end

    assign bus.tone_out  = tone_q;
    assign bus.duracao   = (state_q != StIdle);
    assign bus.note_done = done_q;

endmodule

// File: tb/tb_gerador_nota.sv
// Scoreboard bench for gerador_nota: per-cycle {tone_out, duracao, note_done} expectations.
module tb_gerador_nota;

    localparam int unsigned W = 28;
    localparam int G = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [2:0] exp_q[$];

    gerador_nota_if #(.WIDTH(W)) bus ();

`ifdef NOTE_GAP_EN
    gerador_nota #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`else
    gerador_nota #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got tone/dur/done=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic bit ena_at(input int j, input int ps, input int pl);
        return !(pl > 0 && j >= ps && j < ps + pl);
    endfunction

    // Spec-level model: e = enabled cycles played in the current note
    task automatic push_expected(input int f1, input int d1, input int ps, input int pl,
                                 input int re, input int f2, input int d2, input int n);
        int f, d, e;
        bit act, dn, gap, tone;
        f = 0; d = 0; e = 0; act = 0; gap = 0;
        for (int j = 0; j < n; j++) begin
            dn = 0;
            if (act && ena_at(j, ps, pl)) begin
                e++;
                if (e == d) begin
                    act = 0;
                    dn  = 1;
                end
            end
            if (j == 0 || (re > 0 && j == re)) begin
                f   = (j == 0) ? f1 : f2;
                d   = (j == 0) ? d1 : d2;
                e   = 0;
                act = (d != 0);
                gap = (d > 2 * G);
                if (d == 0) dn = 1;
            end
            tone = act && f > 0 && (((e / f) % 2) == 1);
`ifdef NOTE_GAP_EN
            if (act && gap && e >= d - G) tone = 0;
`endif
            exp_q.push_back({tone, act, dn});
        end
    endtask

    task automatic run(input int id, input int f1, input int d1, input int ps, input int pl,
                       input int re, input int f2, input int d2, input int n);
        logic [2:0] e;
        push_expected(f1, d1, ps, pl, re, f2, d2, n);
        for (int j = 0; j < n; j++) begin
            bus.ena  = ena_at(j, ps, pl);
            bus.load = (j == 0) || (re > 0 && j == re);
            bus.freq_in = W'((j == 0) ? f1 : f2);
            bus.dur_in  = W'((j == 0) ? d1 : d2);
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            if (exp_q.size() == 0) begin
                check_eq("scoreboard_empty", 3'b000, 3'b111);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("s%0d_c%0d", id, j + 1),
                         {bus.tone_out, bus.duracao, bus.note_done}, e);
            end
        end
        bus.ena = 1'b1;
    endtask

    initial begin
        logic [2:0] e;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.load    = 1'b0;
        bus.freq_in = '0;
        bus.dur_in  = '0;
        #12;
        check_eq("reset_state", {bus.tone_out, bus.duracao, bus.note_done}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(1, 3, 12, 0, 0, 0, 0, 0, 14);   // basic tone
        run(2, 0, 5, 0, 0, 0, 0, 0, 7);     // rest
        run(3, 2, 10, 3, 4, 0, 0, 0, 16);   // pause stretches note
        run(4, 2, 20, 0, 0, 7, 5, 6, 16);   // reload mid-note
        run(5, 3, 0, 0, 0, 0, 0, 0, 3);     // zero duration
        run(6, 1, 3, 0, 0, 3, 2, 4, 10);    // reload on expiry cycle
        run(7, 1, 4, 0, 2, 0, 0, 0, 8);     // load while ena low
        run(8, 1, 20, 0, 0, 0, 0, 0, 22);   // long note (gap when enabled)
        run(9, 1, 8, 0, 0, 0, 0, 0, 10);    // boundary: dur == 2*G

        // Asynchronous reset mid-note
        bus.load = 1'b1; bus.freq_in = W'(1); bus.dur_in = W'(10);
        @(posedge clk); #1;
        bus.load = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_reset", {bus.tone_out, bus.duracao, bus.note_done}, 3'b110);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {bus.tone_out, bus.duracao, bus.note_done}, 3'b000);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(3'b000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check_eq($sformatf("post_rst_c%0d", k + 1),
                     {bus.tone_out, bus.duracao, bus.note_done}, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
